// File: rtl/count_one.sv
// Counts ones in in_vec; in CONTINUOUS mode only the unbroken run starting at bit 0 is counted.
module count_one #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic [WIDTH-1:0]       in_vec,
    output logic [$clog2(WIDTH):0] sum
);

    localparam int unsigned SUM_W = $clog2(WIDTH) + 1;

    logic run;

    always_comb begin
        sum = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CONTINUOUS) begin
                run = run & in_vec[i];
            end else begin
                run = in_vec[i];
            end
            if (run) begin
                sum = sum + SUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_port_fifo.sv
// Circular-buffer FIFO moving up to PORT_NUM entries in and out per cycle.
// Pointers carry one extra wrap bit so full and empty never alias.
module multi_port_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PORT_NUM   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] push_data,
    input  logic [PORT_NUM-1:0]                 push_valid,
    output logic [PORT_NUM-1:0]                 push_ready,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0] pop_data,
    output logic [PORT_NUM-1:0]                 pop_valid,
    input  logic [PORT_NUM-1:0]                 pop_ready,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                full,
    output logic                                empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(PORT_NUM) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
        $error("multi_port_fifo: DEPTH must be a power of two");
    end
    if (DEPTH < PORT_NUM) begin : g_depth_ports
        $error("multi_port_fifo: DEPTH must be >= PORT_NUM");
    end

    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      free;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]      push_n;
    logic [CNT_W-1:0]      pop_n;

    count_one #(.WIDTH(PORT_NUM), .CONTINUOUS(1'b1)) u_push_cnt (
        .in_vec (push_valid & push_ready),
        .sum    (push_n)
    );

    count_one #(.WIDTH(PORT_NUM), .CONTINUOUS(1'b1)) u_pop_cnt (
        .in_vec (pop_valid & pop_ready),
        .sum    (pop_n)
    );

    // Status and read lanes depend only on registered state, never on same-cycle handshakes.
    always_comb begin
        count = wptr_q - rptr_q;
        free  = PTR_W'(DEPTH) - count;
        full  = (count == PTR_W'(DEPTH));
        empty = (count == '0);
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            push_ready[i] = (free > PTR_W'(i));
            pop_valid[i]  = (count > PTR_W'(i));
            pop_data[i]   = mem_q[rptr_q[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        mem_d  = mem_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else if (rst) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                if (CNT_W'(i) < push_n) begin
                    mem_d[wptr_q[IDX_W-1:0] + IDX_W'(i)] = push_data[i];
                end
            end
            wptr_d = wptr_q + PTR_W'(push_n);
            rptr_d = rptr_q + PTR_W'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
        mem_q <= mem_d;
    end

endmodule
